// File: rtl/ecc_pkg.sv
// Shared FSM state encoding and special-case codes for the elliptic-curve point unit.
package ecc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t IDLE     = 4'd0;
    localparam state_t CLASSIFY = 4'd1;
    localparam state_t NUM      = 4'd2;
    localparam state_t DEN      = 4'd3;
    localparam state_t INV      = 4'd4;
    localparam state_t LAMBDA   = 4'd5;
    localparam state_t X3       = 4'd6;
    localparam state_t Y3       = 4'd7;
    localparam state_t FINISH   = 4'd8;

    typedef logic [2:0] case_t;

    localparam case_t CASE_ADD    = 3'd0;
    localparam case_t CASE_DOUBLE = 3'd1;
    localparam case_t CASE_RET_P  = 3'd2;
    localparam case_t CASE_RET_Q  = 3'd3;
    localparam case_t CASE_INF    = 3'd4;
    localparam case_t CASE_ERROR  = 3'd5;

endpackage

// File: rtl/mod_inv.sv
// Modular inverse a^-1 mod p (p odd) by binary extended Euclid, one reduction step per cycle.
module mod_inv #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] p,
    output logic         done,
    output logic [N-1:0] result
);

    logic         run_q;
    logic         done_q;
    logic [N-1:0] p_q;
    logic [N-1:0] u_q;
    logic [N-1:0] v_q;
    logic [N-1:0] s_q;
    logic [N-1:0] t_q;
    logic [N-1:0] result_q;
    logic         fin;
    logic [N-1:0] fin_val;

    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] u, input logic [N-1:0] v,
                                             input logic [N-1:0] m);
        return (u >= v) ? (u - v) : (u - v + m);
    endfunction

    // x/2 mod m for odd m: add m first when x is odd so the shift is exact.
    function automatic logic [N-1:0] mod_half(input logic [N-1:0] x, input logic [N-1:0] m);
        logic [N:0] s;
        s = {1'b0, x} + (x[0] ? {1'b0, m} : '0);
        return N'(s >> 1);
    endfunction

    // Invariants: s*a == u and t*a == v (mod p). A zero operand yields 0 rather than hanging.
    always_comb begin
        fin     = 1'b1;
        fin_val = '0;
        if (u_q == N'(1)) begin
            fin_val = s_q;
        end else if (v_q == N'(1)) begin
            fin_val = t_q;
        end else if (u_q != '0) begin
            fin = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            p_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
            s_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (!run_q) begin
                if (start) begin
                    run_q <= 1'b1;
                    p_q   <= p;
                    u_q   <= a;
                    v_q   <= p;
                    s_q   <= N'(1);
                    t_q   <= '0;
                end
            end else if (fin) begin
                run_q    <= 1'b0;
                done_q   <= 1'b1;
                result_q <= fin_val;
            end else if (!u_q[0]) begin
                u_q <= u_q >> 1;
                s_q <= mod_half(s_q, p_q);
            end else if (!v_q[0]) begin
                v_q <= v_q >> 1;
                t_q <= mod_half(t_q, p_q);
            end else if (u_q >= v_q) begin
                u_q <= (u_q - v_q) >> 1;
                s_q <= mod_half(mod_sub(s_q, t_q, p_q), p_q);
            end else begin
                v_q <= (v_q - u_q) >> 1;
                t_q <= mod_half(mod_sub(t_q, s_q, p_q), p_q);
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: rtl/point_add_double.sv
// Affine point addition/doubling on y^2 = x^3 + a*x + b over GF(p), with one shared
// bit-serial modular multiplier and a mod_inv instance for the slope denominator.
module point_add_double
    import ecc_pkg::*;
#(
    parameter int unsigned N            = 16,
    parameter int unsigned CHECK_INPUTS = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] p,
    input  logic [N-1:0] a,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] y2,
    input  logic         inf1,
    input  logic         inf2,
    output logic [N-1:0] x3,
    output logic [N-1:0] y3,
    output logic         inf3,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int unsigned CntW = $clog2(N + 1);

    state_t       state_q;
    logic [N-1:0] p_q, a_q, x1_q, y1_q, x2_q, y2_q;
    logic         inf1_q, inf2_q;
    logic         dbl_q;
    logic [N-1:0] num_q, den_q, inv_q, lam_q;
    logic [N-1:0] x3_q, y3_q;
    logic         inf3_q, busy_q, done_q, error_q;
    logic         inv_start_q;
    logic         inv_done;
    logic [N-1:0] inv_result;
    case_t        cls;

    logic            mul_run_q;
    logic [CntW-1:0] mul_cnt_q;
    logic [N-1:0]    mul_acc_q, mul_u_q, mul_b_q;
    logic [N-1:0]    mul_op_u, mul_op_b, mul_res;
    logic            mul_load, mul_last;

    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] u, input logic [N-1:0] v,
                                             input logic [N-1:0] m);
        return (u >= v) ? (u - v) : (u - v + m);
    endfunction

    // Operands below m, so the raw sum stays below 2m and one correction suffices.
    function automatic logic [N-1:0] mod_add(input logic [N-1:0] u, input logic [N-1:0] v,
                                             input logic [N-1:0] m);
        logic [N:0] s;
        s = {1'b0, u} + {1'b0, v};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return N'(s);
    endfunction

    always_comb begin
        cls = CASE_ADD;
        if (CHECK_INPUTS != 0 && (x1_q >= p_q || y1_q >= p_q || x2_q >= p_q || y2_q >= p_q ||
                                  a_q >= p_q)) begin
            cls = CASE_ERROR;
        end else if (inf1_q) begin
            cls = CASE_RET_Q;
        end else if (inf2_q) begin
            cls = CASE_RET_P;
        end else if (x1_q == x2_q) begin
            cls = (y1_q != y2_q || y1_q == '0) ? CASE_INF : CASE_DOUBLE;
        end
    end

    // Interleaved MSB-first step: acc = 2*acc + b_i*u (mod p).
    assign mul_res  = mod_add(mod_add(mul_acc_q, mul_acc_q, p_q),
                              mul_b_q[N-1] ? mul_u_q : '0, p_q);
    assign mul_last = mul_run_q && (mul_cnt_q == CntW'(1));
    assign mul_load = !mul_run_q && ((state_q == NUM && dbl_q) || state_q == LAMBDA ||
                                     state_q == X3 || state_q == Y3);

    always_comb begin
        mul_op_u = lam_q;
        mul_op_b = lam_q;
        case (state_q)
            NUM: begin
                mul_op_u = x1_q;
                mul_op_b = x1_q;
            end
            LAMBDA: begin
                mul_op_u = num_q;
                mul_op_b = inv_q;
            end
            Y3: mul_op_b = mod_sub(x1_q, x3_q, p_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            p_q         <= '0;
            a_q         <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            inf1_q      <= 1'b0;
            inf2_q      <= 1'b0;
            dbl_q       <= 1'b0;
            num_q       <= '0;
            den_q       <= '0;
            inv_q       <= '0;
            lam_q       <= '0;
            x3_q        <= '0;
            y3_q        <= '0;
            inf3_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            inv_start_q <= 1'b0;
            mul_run_q   <= 1'b0;
            mul_cnt_q   <= '0;
            mul_acc_q   <= '0;
            mul_u_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            inv_start_q <= 1'b0;

            if (mul_run_q) begin
                mul_acc_q <= mul_res;
                mul_b_q   <= mul_b_q << 1;
                mul_cnt_q <= mul_cnt_q - CntW'(1);
                if (mul_last) begin
                    mul_run_q <= 1'b0;
                end
            end else if (mul_load) begin
                mul_run_q <= 1'b1;
                mul_u_q   <= mul_op_u;
                mul_b_q   <= mul_op_b;
                mul_acc_q <= '0;
                mul_cnt_q <= CntW'(N);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        p_q     <= p;
                        a_q     <= a;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        x2_q    <= x2;
                        y2_q    <= y2;
                        inf1_q  <= inf1;
                        inf2_q  <= inf2;
                        busy_q  <= 1'b1;
                        state_q <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    dbl_q   <= (cls == CASE_DOUBLE);
                    x3_q    <= '0;
                    y3_q    <= '0;
                    inf3_q  <= 1'b0;
                    error_q <= 1'b0;
                    state_q <= FINISH;
                    case (cls)
                        CASE_ERROR: error_q <= 1'b1;
                        CASE_RET_Q: begin
                            inf3_q <= inf2_q;
                            x3_q   <= inf2_q ? '0 : x2_q;
                            y3_q   <= inf2_q ? '0 : y2_q;
                        end
                        CASE_RET_P: begin
                            x3_q <= x1_q;
                            y3_q <= y1_q;
                        end
                        CASE_INF: inf3_q <= 1'b1;
                        default:  state_q <= NUM;
                    endcase
                end
                NUM: begin
                    if (!dbl_q) begin
                        num_q   <= mod_sub(y2_q, y1_q, p_q);
                        state_q <= DEN;
                    end else if (mul_last) begin
                        // 3*x1^2 + a
                        num_q   <= mod_add(mod_add(mod_add(mul_res, mul_res, p_q), mul_res, p_q),
                                           a_q, p_q);
                        state_q <= DEN;
                    end
                end
                DEN: begin
                    den_q       <= dbl_q ? mod_add(y1_q, y1_q, p_q) : mod_sub(x2_q, x1_q, p_q);
                    inv_start_q <= 1'b1;
                    state_q     <= INV;
                end
                INV: begin
                    if (inv_done) begin
                        inv_q   <= inv_result;
                        state_q <= LAMBDA;
                    end
                end
                LAMBDA: begin
                    if (mul_last) begin
                        lam_q   <= mul_res;
                        state_q <= X3;
                    end
                end
                X3: begin
                    if (mul_last) begin
                        x3_q    <= mod_sub(mod_sub(mul_res, x1_q, p_q), x2_q, p_q);
                        state_q <= Y3;
                    end
                end
                Y3: begin
                    if (mul_last) begin
                        y3_q    <= mod_sub(mul_res, y1_q, p_q);
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mod_inv #(
        .N(N)
    ) u_mod_inv (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (inv_start_q),
        .a      (den_q),
        .p      (p_q),
        .done   (inv_done),
        .result (inv_result)
    );

    assign x3    = x3_q;
    assign y3    = y3_q;
    assign inf3  = inf3_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_point_add_double.sv
// Directed and randomized checks of point_add_double against a behavioural curve model.
module tb_point_add_double;

    localparam int unsigned N = 16;
    localparam int Limit = 10 * N + 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] p = '0, a = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic         inf1 = 1'b0, inf2 = 1'b0;
    logic [N-1:0] x3, y3;
    logic         inf3, busy, done, error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    point_add_double #(
        .N           (N),
        .CHECK_INPUTS(1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .p      (p),
        .a      (a),
        .x1     (x1),
        .y1     (y1),
        .x2     (x2),
        .y2     (y2),
        .inf1   (inf1),
        .inf2   (inf2),
        .x3     (x3),
        .y3     (y3),
        .inf3   (inf3),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint powmod(input longint b, input longint e, input longint m);
        longint r = 1;
        longint bb = b % m;
        longint ee = e;
        while (ee > 0) begin
            if (ee % 2 == 1) r = (r * bb) % m;
            bb = (bb * bb) % m;
            ee = ee / 2;
        end
        return r;
    endfunction

    // Reference: textbook affine group law, inverse via Fermat's little theorem.
    task automatic model(input longint mp, input longint ma, input longint px, input longint py,
                         input longint qx, input longint qy, input bit i1, input bit i2,
                         output longint rx, output longint ry, output bit ri, output bit re,
                         output bit sp);
        longint num, den, lam;
        rx = 0; ry = 0; ri = 0; re = 0; sp = 1;
        if (px >= mp || py >= mp || qx >= mp || qy >= mp || ma >= mp) begin
            re = 1;
        end else if (i1) begin
            ri = i2;
            if (!i2) begin rx = qx; ry = qy; end
        end else if (i2) begin
            rx = px; ry = py;
        end else if (px == qx && (py != qy || py == 0)) begin
            ri = 1;
        end else begin
            sp = 0;
            if (px == qx) begin
                num = (3 * px * px + ma) % mp;
                den = (2 * py) % mp;
            end else begin
                num = (qy - py + mp) % mp;
                den = (qx - px + mp) % mp;
            end
            lam = (num * powmod(den, mp - 2, mp)) % mp;
            rx = ((lam * lam) % mp - px - qx + 2 * mp) % mp;
            ry = ((lam * ((px - rx + mp) % mp)) % mp - py + mp) % mp;
        end
    endtask

    task automatic check_res(input string tag, input int ex, input int ey, input int ei,
                             input int ee);
        chk({tag, ".x3"}, int'(x3), ex);
        chk({tag, ".y3"}, int'(y3), ey);
        chk({tag, ".inf3"}, int'(inf3), ei);
        chk({tag, ".error"}, int'(error), ee);
    endtask

    // Inputs are scrambled and start re-pulsed while busy; neither may disturb the result.
    task automatic op_check(input string tag, input int tp, input int ta, input int tx1,
                            input int ty1, input int tx2, input int ty2, input bit ti1,
                            input bit ti2, input int ex, input int ey, input int ei, input int ee,
                            input bit special);
        int cyc;
        bit got;
        @(negedge clk);
        p = N'(tp); a = N'(ta); x1 = N'(tx1); y1 = N'(ty1); x2 = N'(tx2); y2 = N'(ty2);
        inf1 = ti1; inf2 = ti2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".busy_accept"}, int'(busy), 1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < Limit + 4) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b1;
                p = N'($urandom); a = N'($urandom); x1 = N'($urandom); y1 = N'($urandom);
                x2 = N'($urandom); y2 = N'($urandom);
                inf1 = 1'(($urandom)); inf2 = 1'(($urandom));
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, int'(got), 1);
        chk({tag, ".latency_bound"}, int'(cyc <= Limit), 1);
        if (special) chk({tag, ".special_latency"}, cyc, 2);
        chk({tag, ".busy_at_done"}, int'(busy), 0);
        check_res(tag, ex, ey, ei, ee);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, int'(done), 0);
        check_res({tag, ".hold"}, ex, ey, ei, ee);
    endtask

    initial begin
        int primes[5] = '{17, 97, 251, 8191, 32749};
        longint rx, ry;
        bit ri, re, sp;
        int tp, ta, px, py, qx, qy, mode;
        bit i1, i2;

        #1;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.error", int'(error), 0);
        chk("reset.inf3", int'(inf3), 0);
        chk("reset.x3", int'(x3), 0);
        chk("reset.y3", int'(y3), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        op_check("double", 17, 2, 5, 1, 5, 1, 0, 0, 6, 3, 0, 0, 0);
        op_check("add", 17, 2, 5, 1, 6, 3, 0, 0, 10, 6, 0, 0, 0);
        op_check("inverse", 17, 2, 5, 16, 5, 1, 0, 0, 0, 0, 1, 0, 1);
        op_check("inf1", 17, 2, 0, 0, 5, 1, 1, 0, 5, 1, 0, 0, 1);
        op_check("inf_both", 17, 2, 5, 1, 5, 1, 1, 1, 0, 0, 1, 0, 1);
        op_check("err", 17, 2, 17, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1);
        op_check("err_clear", 17, 2, 5, 1, 6, 3, 0, 0, 10, 6, 0, 0, 0);

        // Reset three cycles into a doubling, then a fresh doubling must still be correct.
        @(negedge clk);
        p = 17; a = 2; x1 = 5; y1 = 1; x2 = 5; y2 = 1; inf1 = 0; inf2 = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset.busy", int'(busy), 0);
        chk("midreset.done", int'(done), 0);
        chk("midreset.x3", int'(x3), 0);
        @(negedge clk);
        reset_n = 1'b1;
        op_check("after_reset", 17, 2, 5, 1, 5, 1, 0, 0, 6, 3, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            tp = primes[$urandom_range(0, 4)];
            ta = int'($urandom % tp);
            px = int'($urandom % tp);
            py = int'($urandom % tp);
            qx = int'($urandom % tp);
            qy = int'($urandom % tp);
            i1 = 1'b0;
            i2 = 1'b0;
            mode = $urandom_range(0, 7);
            case (mode)
                0: begin qx = px; qy = py; end
                1: begin qx = px; qy = (tp - py) % tp; end
                2: i1 = 1'b1;
                3: i2 = 1'b1;
                4: begin py = 0; qx = px; qy = 0; end
                5: qx = tp + $urandom_range(0, 100);
                default: ;
            endcase
            model(tp, ta, px, py, qx, qy, i1, i2, rx, ry, ri, re, sp);
            op_check("random", tp, ta, px, py, qx, qy, i1, i2, int'(rx), int'(ry), int'(ri),
                     int'(re), sp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
